acq_search_ctrl: RTL and testbench
==================================

Name: acq_search_ctrl

Overview:
- Serial code-phase search sequencer for one GPS acquisition channel.
- Integrates 1-bit I/Q correlator outputs coherently over one code period, then squares I and Q on a single time-shared multiplier.
- Accumulates energy non-coherently over NONCOH periods, slips the local code one sample, and repeats for every phase.
- Reports the best phase, its energy and a threshold detect to the tracking hand-off logic.

Parameters:
- CODE_LEN, 1023, valid samples per coherent period; also the number of code phases searched; must be ≥3.
- NONCOH, 4, coherent periods summed per phase; must be ≥1.
- ACC_W, 12, signed coherent accumulator width; must hold ±CODE_LEN.
- E_W, 28, unsigned energy width.
- PH_W, 10, code phase index width; must satisfy 2^PH_W ≥ CODE_LEN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a search; ignored unless idle
- threshold  in  E_W  detect threshold, sampled at start
- sample_valid  in  1  correlator sample present this cycle
- corr_i  in  1  in-phase sign bit (1 = +1, 0 = −1)
- corr_q  in  1  quadrature sign bit, same mapping
- in_ready  out  1  block consumes samples this cycle
- code_slip  out  1  one-cycle pulse telling the code generator to delay by one sample
- busy  out  1  search in progress
- done  out  1  one-cycle pulse when the search completes
- best_phase  out  PH_W  phase index holding maximum energy
- best_energy  out  E_W  maximum energy found
- detected  out  1  best_energy > latched threshold

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulators, counters, phase index, best registers and latched threshold cleared. Reset mid-search aborts to IDLE with no done pulse.
- States: IDLE, INTEG, SQ_I, SQ_Q, EVAL, SLIP, FIN.
- IDLE: on start, latch threshold; clear phase, best_energy, best_phase and energy; go to INTEG. busy=1 in every state except IDLE.
- INTEG: in_ready=1. Each cycle with sample_valid, I_acc += (corr_i ? +1 : −1) and Q_acc likewise; the sample counter increments.
  - When the CODE_LEN-th sample is taken, latch I_acc/Q_acc, clear the accumulators and the sample counter, and go to SQ_I.
- in_ready=0 in all states other than INTEG. Samples presented while in_ready=0 are dropped, not buffered.
- SQ_I: energy += I_lat*I_lat using the shared multiplier. Next state SQ_Q.
- SQ_Q: energy += Q_lat*Q_lat. Increment the period counter.
  - If period counter < NONCOH, go to INTEG.
  - Otherwise clear the period counter and go to EVAL.
- Squares are computed signed, so the product is always non-negative. Energy addition saturates at 2^E_W−1.
- EVAL: if energy > best_energy (strict), best_energy←energy and best_phase←phase. Ties keep the earlier phase. Clear energy.
  - If phase == CODE_LEN−1, go to FIN.
  - Otherwise go to SLIP.
- SLIP: code_slip=1 for exactly this cycle; phase += 1; go to INTEG.
- FIN: done=1 for one cycle; detected ← (best_energy > threshold); go to IDLE.
- In IDLE, best_phase, best_energy and detected hold their values until the next start.
- A start pulse outside IDLE is ignored.
- Latency: last sample of the last period → energy final after 2 cycles → EVAL on cycle 3 → code_slip on cycle 4. For the final phase, done is asserted on cycle 4.
- Search duration with continuous sample_valid: CODE_LEN·(NONCOH·(CODE_LEN+2)+2) cycles.

Optional Feature:
- Macro: ACQ_EARLY_STOP_EN.
- Defined: in EVAL, if energy > threshold, jump directly to FIN regardless of phase. The best registers are updated first, so best_phase is the detecting phase, detected=1, and no further slips occur.
- Undefined: all CODE_LEN phases are always searched; the detect decision is made only in FIN.

Test Plan:
- CODE_LEN=8, NONCOH=2, threshold=200. Feed alternating corr_i/corr_q (I=Q=0) on every phase except phase 5, which gets all ones → best_phase=5, best_energy=256, detected=1, done once, 7 code_slip pulses.
- Same config with all phases zero-energy → best_phase=0 (tie rule), best_energy=0, detected=0.
- All ones on phase 2, all zeros on phase 6 (both energy 256) → best_phase=2 (strict > keeps the earlier phase).
- Deassert sample_valid randomly at 50% during INTEG; drive sample_valid=1 during SQ_I/SQ_Q/SLIP → those samples are dropped and results are identical to the first test.
- Assert rst during the SQ_Q of phase 3 → next cycle all outputs 0 and IDLE; a fresh start gives correct results. A start pulse while busy has no effect.
- ACQ_EARLY_STOP_EN defined, strong signal on phase 3, threshold=200 → done after EVAL of phase 3, best_phase=3, exactly 3 code_slip pulses.

Source files
------------

// File: rtl/acq_search_ctrl.sv
// acq_search_ctrl: serial code-phase search sequencer for one GPS acquisition
// channel. Coherently integrates 1-bit I/Q correlator samples over one code
// period. It squares I and Q on one shared multiplier and sums the energy
// over NONCOH periods. After each phase it slips the local code by one
// sample, and it reports the strongest phase.
//
// Optional feature, selected with the macro ACQ_EARLY_STOP_EN: the search
// ends at the first phase whose energy exceeds the latched threshold.
module acq_search_ctrl #(
  parameter int CODE_LEN = 1023,
  parameter int NONCOH   = 4,
  parameter int ACC_W    = 12,
  parameter int E_W      = 28,
  parameter int PH_W     = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [E_W-1:0]  threshold,
  input  logic            sample_valid,
  input  logic            corr_i,
  input  logic            corr_q,
  output logic            in_ready,
  output logic            code_slip,
  output logic            busy,
  output logic            done,
  output logic [PH_W-1:0] best_phase,
  output logic [E_W-1:0]  best_energy,
  output logic            detected
);

  localparam int SC_W  = $clog2(CODE_LEN + 1);
  localparam int PC_W  = $clog2(NONCOH + 1);
  localparam int SQ_W  = 2 * ACC_W;
  localparam int SUM_W = ((E_W > SQ_W) ? E_W : SQ_W) + 1;
  localparam logic [E_W-1:0] E_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, INTEG, SQ_I, SQ_Q, EVAL, SLIP, FIN
  } state_t;

  state_t state, state_next;

  logic signed [ACC_W-1:0] i_acc, q_acc, i_lat, q_lat;
  logic signed [ACC_W-1:0] i_sum, q_sum, mul_op;
  logic signed [SQ_W-1:0]  mul_ext, sq;
  logic [SC_W-1:0]         sample_cnt;
  logic [PC_W-1:0]         period_cnt;
  logic [PH_W-1:0]         phase;
  logic [E_W-1:0]          energy, energy_add, thr_lat;
  logic [SUM_W-1:0]        sum_ext;
  logic                    take, last_sample, last_period, last_phase, better;
`ifdef ACQ_EARLY_STOP_EN
  logic                    early_hit;
`endif

  // Sample arithmetic, the shared squarer and the saturating energy adder
  always_comb begin
    take        = (state == INTEG) && sample_valid;
    last_sample = take && (sample_cnt == SC_W'(CODE_LEN - 1));
    last_period = (period_cnt == PC_W'(NONCOH - 1));
    last_phase  = (phase == PH_W'(CODE_LEN - 1));
    i_sum       = corr_i ? i_acc + ACC_W'(1) : i_acc - ACC_W'(1);
    q_sum       = corr_q ? q_acc + ACC_W'(1) : q_acc - ACC_W'(1);
    mul_op      = (state == SQ_Q) ? q_lat : i_lat;
    mul_ext     = SQ_W'(mul_op);
    sq          = mul_ext * mul_ext;
    sum_ext     = SUM_W'(energy) + SUM_W'($unsigned(sq));
    energy_add  = (sum_ext > SUM_W'(E_MAX)) ? E_MAX : sum_ext[E_W-1:0];
    better      = energy > best_energy;
`ifdef ACQ_EARLY_STOP_EN
    early_hit   = energy > thr_lat;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and the per-state control outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    code_slip  = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:  if (start) state_next = INTEG;
      INTEG: begin
        in_ready = 1'b1;
        if (last_sample) state_next = SQ_I;
      end
      SQ_I:  state_next = SQ_Q;
      SQ_Q:  state_next = last_period ? EVAL : INTEG;
      EVAL: begin
        state_next = last_phase ? FIN : SLIP;
`ifdef ACQ_EARLY_STOP_EN
        if (early_hit) state_next = FIN;
`endif
      end
      SLIP: begin
        code_slip  = 1'b1;
        state_next = INTEG;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: accumulators, counters, energy and best-phase tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      i_acc       <= '0;
      q_acc       <= '0;
      i_lat       <= '0;
      q_lat       <= '0;
      sample_cnt  <= '0;
      period_cnt  <= '0;
      phase       <= '0;
      energy      <= '0;
      thr_lat     <= '0;
      best_energy <= '0;
      best_phase  <= '0;
      detected    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            thr_lat     <= threshold;
            phase       <= '0;
            best_energy <= '0;
            best_phase  <= '0;
            energy      <= '0;
            detected    <= 1'b0;
            i_acc       <= '0;
            q_acc       <= '0;
            sample_cnt  <= '0;
            period_cnt  <= '0;
          end
        end
        INTEG: begin
          if (last_sample) begin
            i_lat      <= i_sum;
            q_lat      <= q_sum;
            i_acc      <= '0;
            q_acc      <= '0;
            sample_cnt <= '0;
          end else if (take) begin
            i_acc      <= i_sum;
            q_acc      <= q_sum;
            sample_cnt <= sample_cnt + SC_W'(1);
          end
        end
        SQ_I: energy <= energy_add;
        SQ_Q: begin
          energy     <= energy_add;
          period_cnt <= last_period ? '0 : period_cnt + PC_W'(1);
        end
        EVAL: begin
          if (better) begin
            best_energy <= energy;
            best_phase  <= phase;
          end
          energy <= '0;
        end
        SLIP: phase <= phase + PH_W'(1);
        FIN:  detected <= (best_energy > thr_lat);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_search_ctrl.sv
// tb_acq_search_ctrl: scoreboard bench for acq_search_ctrl with a short code
// (CODE_LEN=8, NONCOH=2). Each search pushes its expected result. A monitor
// pops that result when done pulses and compares it with the DUT outputs.
module tb_acq_search_ctrl;

  localparam int CODE_LEN = 8;
  localparam int NONCOH   = 2;
  localparam int ACC_W    = 12;
  localparam int E_W      = 28;
  localparam int PH_W     = 10;
`ifdef ACQ_EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [E_W-1:0]  threshold;
  logic            sample_valid;
  logic            corr_i;
  logic            corr_q;
  logic            in_ready;
  logic            code_slip;
  logic            busy;
  logic            done;
  logic [PH_W-1:0] best_phase;
  logic [E_W-1:0]  best_energy;
  logic            detected;

  typedef struct {
    int     phase;
    longint energy;
    bit     det;
    int     slips;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Per-phase pattern: 0 alternating (zero energy), 1 all ones, 2 all zeros
  logic [1:0] phase_mode [CODE_LEN];
  bit         drop_en = 1'b0;
  bit         junk_en = 1'b0;
  int         acc_cnt = 0;
  int         drv_phase = 0;
  int         slips_seen = 0;

  acq_search_ctrl #(
    .CODE_LEN(CODE_LEN), .NONCOH(NONCOH), .ACC_W(ACC_W), .E_W(E_W), .PH_W(PH_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .sample_valid(sample_valid), .corr_i(corr_i), .corr_q(corr_q),
    .in_ready(in_ready), .code_slip(code_slip), .busy(busy), .done(done),
    .best_phase(best_phase), .best_energy(best_energy), .detected(detected)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Track accepted samples, the current code phase and slip pulses
  always @(posedge clk) begin
    if (rst || (start && !busy)) begin
      acc_cnt    <= 0;
      drv_phase  <= 0;
      slips_seen <= 0;
    end else begin
      if (in_ready && sample_valid) acc_cnt <= acc_cnt + 1;
      if (code_slip) begin
        drv_phase  <= drv_phase + 1;
        slips_seen <= slips_seen + 1;
      end
    end
  end

  // Sample driver: drive the phase pattern while ready, junk samples otherwise
  initial begin
    logic [1:0] pm;
    sample_valid = 1'b0;
    corr_i = 1'b0;
    corr_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!in_ready) begin
        sample_valid = junk_en;
        corr_i = 1'b1;
        corr_q = 1'b1;
      end else begin
        pm = (drv_phase >= 0 && drv_phase < CODE_LEN) ? phase_mode[drv_phase] : 2'd0;
        sample_valid = drop_en ? 1'($urandom_range(0, 1)) : 1'b1;
        case (pm)
          2'd1:    begin corr_i = 1'b1; corr_q = 1'b1; end
          2'd2:    begin corr_i = 1'b0; corr_q = 1'b0; end
          default: begin corr_i = acc_cnt[0]; corr_q = acc_cnt[0]; end
        endcase
      end
    end
  end

  // Monitor: compare each done pulse against the oldest expected result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_done: got done=1, expected no done");
        end else begin
          e = exp_q.pop_front();
          check_output("best_phase", longint'(best_phase), longint'(e.phase));
          check_output("best_energy", longint'(best_energy), e.energy);
          check_output("slip_count", longint'(slips_seen), longint'(e.slips));
          @(negedge clk);
          check_output("detected", longint'(detected), longint'(e.det));
          check_output("done_width", longint'(done), 0);
        end
      end
    end
  end

  task automatic set_modes(input int ones_ph, input int zeros_ph);
    for (int p = 0; p < CODE_LEN; p++) phase_mode[p] = 2'd0;
    if (ones_ph >= 0)  phase_mode[ones_ph]  = 2'd1;
    if (zeros_ph >= 0) phase_mode[zeros_ph] = 2'd2;
  endtask

  task automatic apply_stimulus(input longint thr, input bit poke,
                                input int exp_phase, input longint exp_energy);
    exp_t e;
    int   n;
    e.phase  = exp_phase;
    e.energy = exp_energy;
    e.det    = (exp_energy > thr);
    e.slips  = (EARLY && e.det) ? exp_phase : CODE_LEN - 1;
    exp_q.push_back(e);
    @(negedge clk);
    threshold = E_W'(thr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    threshold = '0;
    if (poke) begin
      repeat (30) @(negedge clk);
      start = 1'b1;
      threshold = '1;
      @(negedge clk);
      start = 1'b0;
      threshold = '0;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL search_timeout: got no done in %0d cycles, expected done", n);
      exp_q.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  // Directed test sequence
  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    threshold = '0;
    set_modes(-1, -1);
    repeat (3) @(negedge clk);
    check_output("reset_busy", longint'(busy), 0);
    check_output("reset_in_ready", longint'(in_ready), 0);
    check_output("reset_done", longint'(done), 0);
    check_output("reset_code_slip", longint'(code_slip), 0);
    check_output("reset_best_phase", longint'(best_phase), 0);
    check_output("reset_best_energy", longint'(best_energy), 0);
    check_output("reset_detected", longint'(detected), 0);
    rst = 1'b0;
    @(negedge clk);

    // Strong phase 5 with a start pulse while busy that must be ignored
    set_modes(5, -1);
    apply_stimulus(200, 1'b1, 5, 256);

    // No signal anywhere: the earliest phase wins the all-zero tie
    set_modes(-1, -1);
    apply_stimulus(200, 1'b0, 0, 0);

    // Equal energy on phases 2 and 6: the earlier phase is kept
    set_modes(2, 6);
    apply_stimulus(200, 1'b0, 2, 256);

    // Random gaps in sample_valid and junk samples outside INTEG
    set_modes(5, -1);
    drop_en = 1'b1;
    junk_en = 1'b1;
    apply_stimulus(200, 1'b0, 5, 256);
    drop_en = 1'b0;
    junk_en = 1'b0;

    // Energy equal to the threshold does not count as a detection
    set_modes(5, -1);
    apply_stimulus(256, 1'b0, 5, 256);

    // Reset during phase 3 aborts the search
    set_modes(1, -1);
    @(negedge clk);
    threshold = '1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    threshold = '0;
    n = 0;
    while (!(drv_phase == 3 && busy && !in_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_output("reach_phase3_sq", longint'(drv_phase == 3 && busy && !in_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("abort_busy", longint'(busy), 0);
    check_output("abort_in_ready", longint'(in_ready), 0);
    check_output("abort_done", longint'(done), 0);
    check_output("abort_code_slip", longint'(code_slip), 0);
    check_output("abort_best_phase", longint'(best_phase), 0);
    check_output("abort_best_energy", longint'(best_energy), 0);
    check_output("abort_detected", longint'(detected), 0);
    rst = 1'b0;
    @(negedge clk);
    set_modes(5, -1);
    apply_stimulus(200, 1'b0, 5, 256);

    // Strong phase 3 (stops early when the early-stop feature is built in)
    set_modes(3, -1);
    apply_stimulus(200, 1'b0, 3, 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
